// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
//   pc_sel_e          : next-PC source select
//   PC_RESET_DEFAULT  : default PC loaded on reset
//   ras_ptr_w()       : pointer width for a return stack of a given depth
package pc_pkg;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JMP,
        SEL_RET
    } pc_sel_e;

    localparam int unsigned PC_RESET_DEFAULT = 0;

    // Depth is a power of two, so the pointer wraps naturally at this width.
    function automatic int unsigned ras_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack with saturating count and sticky error flag.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   push_i         : push push_data_i (overwrites oldest entry when full)
//   pop_i          : pop top entry; push_i & pop_i replaces the top entry
//   push_data_i    : data to push
//   top_o          : current top entry
//   empty_o/full_o : count is 0 / RAS_DEPTH
//   err_o          : sticky overflow/underflow flag, cleared only by reset
module return_stack
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             err_o
);

    localparam int unsigned PW = ras_ptr_w(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             wr_en;
    logic [PW-1:0]    wr_idx;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(RAS_DEPTH));
    assign top_o   = mem_q[ptr_q];
    assign err_o   = err_q;

    // ptr_q addresses the top entry; a push pre-increments, so when full the
    // slot written is the oldest one (circular overwrite).
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (push_i && pop_i && !empty_o) begin
            // Return and call in one cycle: swap the top entry in place.
            wr_en  = 1'b1;
            wr_idx = ptr_q;
        end else if (push_i) begin
            ptr_d  = ptr_q + 1'b1;
            wr_en  = 1'b1;
            wr_idx = ptr_d;
            if (full_o) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            // pop_i here means call+ret on an empty stack: underflow.
            if (pop_i) begin
                err_d = 1'b1;
            end
        end else if (pop_i) begin
            if (empty_o) begin
                err_d = 1'b1;
            end else begin
                ptr_d = ptr_q - 1'b1;
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Entry contents need no reset; validity is tracked by cnt_q.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, PC+1 and branch adders, next-PC
// select and a return-address stack for call/return.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   stall_i           : hold PC and RAS, ignore all controls
//   branch_taken_i    : PC-relative branch to sign_imm_i + pc + 1
//   sign_imm_i        : signed branch offset
//   jump_i, call_i    : absolute jump to jump_target_i (call also pushes pc + 1)
//   jump_target_i     : absolute target
//   ret_i             : jump to RAS top and pop
//   pc_o              : registered PC
//   pc_plus1_o        : pc + 1
//   next_pc_o         : PC loaded at the next edge
//   ras_empty_o/full_o: RAS occupancy
//   ras_err_o         : sticky RAS overflow/underflow
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned     WIDTH     = 32,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(PC_RESET_DEFAULT)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic [WIDTH-1:0] sign_imm_i,
    input  logic             jump_i,
    input  logic             call_i,
    input  logic [WIDTH-1:0] jump_target_i,
    input  logic             ret_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus1_o,
    output logic [WIDTH-1:0] next_pc_o,
    output logic             ras_empty_o,
    output logic             ras_full_o,
    output logic             ras_err_o
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] ras_top;
    logic [WIDTH-1:0] sel_pc;
    logic             ras_push, ras_pop;
    pc_sel_e          sel;

    assign pc_plus1_o = pc_q + 1'b1;
    assign br_target  = sign_imm_i + pc_plus1_o;

    // Stall masks every control so the RAS sees nothing this cycle.
    assign ras_push = call_i & ~stall_i;
    assign ras_pop  = ret_i & ~stall_i;

    return_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_plus1_o),
        .top_o       (ras_top),
        .empty_o     (ras_empty_o),
        .full_o      (ras_full_o),
        .err_o       (ras_err_o)
    );

    // Priority: ret > call/jump > branch > sequential. A ret on an empty
    // stack falls through to sequential rather than to lower priorities.
    always_comb begin
        sel = SEL_SEQ;
        if (ret_i) begin
            sel = ras_empty_o ? SEL_SEQ : SEL_RET;
        end else if (call_i || jump_i) begin
            sel = SEL_JMP;
        end else if (branch_taken_i) begin
            sel = SEL_BR;
        end
    end

    always_comb begin
        sel_pc = pc_plus1_o;
        unique case (sel)
            SEL_RET: sel_pc = ras_top;
            SEL_JMP: sel_pc = jump_target_i;
            SEL_BR:  sel_pc = br_target;
            default: sel_pc = pc_plus1_o;
        endcase
    end

    assign next_pc_o = stall_i ? pc_q : sel_pc;
    assign pc_d      = next_pc_o;
    assign pc_o      = pc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int unsigned W = 32;
    localparam int unsigned D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         st = 1'b0, br = 1'b0, jp = 1'b0, cl = 1'b0, rt = 1'b0;
    logic [W-1:0] imm = '0, tgt = '0;
    logic [W-1:0] pc, pcp1, npc;
    logic         emp, ful, err;

    int checks = 0;
    int errors = 0;

    // Reference model: PC value plus a bounded queue of return addresses.
    logic [W-1:0] m_pc;
    logic [W-1:0] ras_q[$];
    logic         m_err;

    pc_sequencer #(
        .WIDTH     (W),
        .RAS_DEPTH (D),
        .RESET_PC  ('0)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .stall_i        (st),
        .branch_taken_i (br),
        .sign_imm_i     (imm),
        .jump_i         (jp),
        .call_i         (cl),
        .jump_target_i  (tgt),
        .ret_i          (rt),
        .pc_o           (pc),
        .pc_plus1_o     (pcp1),
        .next_pc_o      (npc),
        .ras_empty_o    (emp),
        .ras_full_o     (ful),
        .ras_err_o      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    function automatic logic [W-1:0] model_next();
        logic [W-1:0] p1;
        p1 = m_pc + 1;
        if (st) return m_pc;
        if (rt) return (ras_q.size() != 0) ? ras_q[ras_q.size()-1] : p1;
        if (cl || jp) return tgt;
        if (br) return imm + p1;
        return p1;
    endfunction

    task automatic model_commit(input logic [W-1:0] nxt);
        logic [W-1:0] p1;
        p1 = m_pc + 1;
        if (!st) begin
            if (cl && rt) begin
                if (ras_q.size() != 0) ras_q[ras_q.size()-1] = p1;
                else begin
                    ras_q.push_back(p1);
                    m_err = 1'b1;
                end
            end else if (cl) begin
                if (ras_q.size() == D) begin
                    void'(ras_q.pop_front());
                    m_err = 1'b1;
                end
                ras_q.push_back(p1);
            end else if (rt) begin
                if (ras_q.size() != 0) void'(ras_q.pop_back());
                else m_err = 1'b1;
            end
            m_pc = nxt;
        end
    endtask

    task automatic model_reset();
        m_pc  = '0;
        ras_q.delete();
        m_err = 1'b0;
    endtask

    task automatic drive(input logic s, input logic b, input logic j, input logic c,
                         input logic r, input logic [W-1:0] i, input logic [W-1:0] t);
        st = s; br = b; jp = j; cl = c; rt = r; imm = i; tgt = t;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Advance one clock: update model at the edge, return at the next negedge.
    task automatic step();
        logic [W-1:0] nxt;
        nxt = model_next();
        @(posedge clk);
        model_commit(nxt);
        @(negedge clk);
    endtask

    task automatic jump_to(input logic [W-1:0] t);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, t);
        step();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", pc); end
        checks++; if ({emp, ful, err} !== 3'b100) begin
            errors++; $display("FAIL reset_flags: got e/f/err=%b want 100", {emp, ful, err});
        end
        for (int i = 1; i <= 3; i++) begin
            idle();
            step();
            checks++; if (pc !== W'(i)) begin
                errors++; $display("FAIL idle_pc: got %0d want %0d", pc, i);
            end
        end
        // Underflow to set the sticky flag, then prove reset clears it.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        step();
        checks++; if (pc !== 32'd4 || err !== 1'b1) begin
            errors++; $display("FAIL ret_empty: got pc=%0d err=%b want pc=4 err=1", pc, err);
        end
        jump_to(32'd7);
        checks++; if (pc !== 32'd7) begin errors++; $display("FAIL jump7: got %0d want 7", pc); end
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pc !== 32'd0 || err !== 1'b0 || emp !== 1'b1) begin
            errors++; $display("FAIL async_reset: got pc=%0d err=%b empty=%b want 0/0/1", pc, err, emp);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_branch();
        jump_to(32'd10);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd5, '0);
        #1;
        checks++; if (npc !== 32'd16) begin errors++; $display("FAIL br_fwd: got %0d want 16", npc); end
        step();
        checks++; if (pc !== 32'd16) begin errors++; $display("FAIL br_fwd_pc: got %0d want 16", pc); end
        jump_to(32'd10);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF5, '0);
        #1;
        checks++; if (npc !== 32'd0) begin errors++; $display("FAIL br_back: got %0d want 0", npc); end
        step();
        jump_to(32'hFFFF_FFFF);
        idle();
        #1;
        checks++; if (npc !== 32'd0 || pcp1 !== 32'd0) begin
            errors++; $display("FAIL wrap: got next=%0h plus1=%0h want 0/0", npc, pcp1);
        end
        step();
        checks++; if (pc !== 32'd0) begin errors++; $display("FAIL wrap_pc: got %0h want 0", pc); end
    endtask

    task automatic test_stall();
        jump_to(32'd39);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 32'd100);
        step();
        checks++; if (pc !== 32'd100) begin errors++; $display("FAIL call100: got %0d want 100", pc); end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd3, 32'd77);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (npc !== 32'd100) begin
                errors++; $display("FAIL stall_next: got %0d want 100", npc);
            end
            step();
            checks++; if (pc !== 32'd100 || emp !== 1'b0 || ful !== 1'b0 || err !== 1'b0) begin
                errors++; $display("FAIL stall_hold: got pc=%0d e/f/err=%b%b%b want 100 000", pc, emp, ful, err);
            end
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd5, 32'd77);
        #1;
        checks++; if (npc !== 32'd40) begin errors++; $display("FAIL ret_prio: got %0d want 40", npc); end
        step();
        checks++; if (pc !== 32'd40 || emp !== 1'b1) begin
            errors++; $display("FAIL ret_prio_pc: got pc=%0d empty=%b want 40/1", pc, emp);
        end
    endtask

    task automatic test_nested();
        logic [W-1:0] exp_pc [4];
        exp_pc = '{32'd20, 32'd30, 32'd21, 32'd6};
        jump_to(32'd5);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 32'd20);
            else if (i == 1) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 32'd30);
            else drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
            step();
            checks++; if (pc !== exp_pc[i]) begin
                errors++; $display("FAIL nested_%0d: got %0d want %0d", i, pc, exp_pc[i]);
            end
        end
        checks++; if (emp !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL nested_end: got empty=%b err=%b want 1/0", emp, err);
        end
    endtask

    task automatic test_overflow();
        jump_to(32'd1);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, W'(k + 2));
            step();
            checks++; if (pc !== W'(k + 2)) begin
                errors++; $display("FAIL ovf_call_%0d: got %0d want %0d", k, pc, k + 2);
            end
            if (k >= 3) begin
                checks++; if (ful !== 1'b1 || err !== (k == 4)) begin
                    errors++; $display("FAIL ovf_flags_%0d: got full=%b err=%b want 1/%0d", k, ful, err, k == 4);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
            step();
            checks++; if (pc !== W'(6 - k)) begin
                errors++; $display("FAIL ovf_ret_%0d: got %0d want %0d", k, pc, 6 - k);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        #1;
        checks++; if (npc !== 32'd4) begin errors++; $display("FAIL udf_next: got %0d want 4", npc); end
        step();
        checks++; if (err !== 1'b1 || emp !== 1'b1) begin
            errors++; $display("FAIL udf_flags: got err=%b empty=%b want 1/1", err, emp);
        end
    endtask

    task automatic test_call_ret();
        do_reset();
        jump_to(32'd49);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 32'd8);
        step();
        checks++; if (pc !== 32'd8) begin errors++; $display("FAIL cr_setup: got %0d want 8", pc); end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0, 32'd123);
        #1;
        checks++; if (npc !== 32'd50) begin errors++; $display("FAIL cr_next: got %0d want 50", npc); end
        step();
        checks++; if (pc !== 32'd50 || emp !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL cr_state: got pc=%0d empty=%b err=%b want 50/0/0", pc, emp, err);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        #1;
        checks++; if (npc !== 32'd9) begin errors++; $display("FAIL cr_ret: got %0d want 9", npc); end
        step();
        checks++; if (pc !== 32'd9 || emp !== 1'b1) begin
            errors++; $display("FAIL cr_ret_pc: got pc=%0d empty=%b want 9/1", pc, emp);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_n;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom % 8) == 0, ($urandom % 3) == 0, ($urandom % 6) == 0,
                  ($urandom % 4) == 0, ($urandom % 4) == 0,
                  W'($urandom_range(0, 64)) - W'(32), $urandom);
            #1;
            exp_n = model_next();
            checks++; if (npc !== exp_n || pcp1 !== m_pc + 1) begin
                errors++;
                $display("FAIL rnd_next_%0d: got next=%0h plus1=%0h want %0h/%0h", n, npc, pcp1, exp_n, m_pc + 1);
            end
            step();
            checks++; if (pc !== m_pc || emp !== (ras_q.size() == 0) || ful !== (ras_q.size() == D)
                          || err !== m_err) begin
                errors++;
                $display("FAIL rnd_state_%0d: got pc=%0h e/f/err=%b%b%b want %0h %b%b%b", n, pc, emp, ful,
                         err, m_pc, ras_q.size() == 0, ras_q.size() == D, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stall();
        test_nested();
        test_overflow();
        test_call_ret();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer for the processor front end. It replaces the stand-alone branch-target adder.
- Holds the registered PC, produces PC+1, and selects the next PC from four sources: sequential, branch (sign_imm + PC+1), jump/call target, and return.
- Contains a circular return-address stack (RAS) so call/return needs no register-file traffic.
- PC is word-addressed; the sequential increment is 1.

Parameters:
- WIDTH, 32, bit width of PC, immediate and targets.
- RAS_DEPTH, 4, number of return-address entries (power of two, >= 2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- stall  in  1  hold PC and RAS; all control inputs ignored this cycle.
- branch_taken  in  1  take PC-relative branch.
- sign_imm  in  WIDTH  signed branch offset, relative to PC+1.
- jump  in  1  absolute jump to jump_target.
- call  in  1  absolute jump to jump_target and push PC+1.
- jump_target  in  WIDTH  absolute target for jump/call.
- ret  in  1  jump to top of RAS and pop.
- pc  out  WIDTH  current PC (registered).
- pc_plus1  out  WIDTH  pc + 1, combinational.
- next_pc  out  WIDTH  PC to be loaded at next edge, combinational.
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_err  out  1  sticky: set on overflow push or underflow pop.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: pc=RESET_PC, RAS count=0, top pointer=0, ras_err=0, ras_empty=1, ras_full=0. RAS entry contents are don't-care.
- Reset mid-operation: all state is reset immediately, with no pending update.
- Arithmetic: all additions are modulo 2^WIDTH with wrap and no flag.
  - pc_plus1 = pc+1.
  - Branch target = sign_imm + pc_plus1, two's complement.
  - pc = all-ones wraps next_pc to 0 on the sequential path.
- next_pc priority, first match wins:
  - stall: next_pc = pc.
  - ret: next_pc = RAS top; if the RAS is empty, next_pc = pc_plus1.
  - call or jump: next_pc = jump_target.
  - branch_taken: next_pc = sign_imm + pc_plus1.
  - Otherwise: next_pc = pc_plus1.
- Latency: pc <= next_pc at every rising edge, giving a one-cycle redirect. next_pc is visible in the same cycle as its controls.
- RAS updates (only when stall=0):
  - call alone: push pc_plus1.
    - If not full: count+1.
    - If full: overwrite the oldest entry (circular wrap), count stays RAS_DEPTH, ras_err<=1.
  - ret alone:
    - If not empty: pop, count-1.
    - If empty: no pointer change, ras_err<=1.
  - call and ret together: next_pc = current top, and the top entry is replaced with pc_plus1. Pointer and count are unchanged.
    - If empty: behaves as a plain push, and ras_err<=1 for the underflow.
  - jump and branch_taken never touch the RAS.
- Stall: freezes pc, the RAS pointer, count and ras_err. Outputs stay stable.
- ras_err clears only on reset.
- ras_empty and ras_full are decoded combinationally from the registered count.

Decomposition:
- Shared package pc_pkg holds:
  - Next-PC select enum: SEL_SEQ, SEL_BR, SEL_JMP, SEL_RET.
  - RESET_PC default constant.
  - RAS pointer width function, clog2(RAS_DEPTH).
- One sub-module, return_stack (parametrised WIDTH, RAS_DEPTH), contains:
  - Circular buffer, top pointer, saturating count and the error flag.
  - Ports: push, pop, push_data, top, empty, full, err, plus clk and rst_n.
- pc_sequencer contains the select logic, the adders and the PC register.

Test Plan:
- Reset, then 3 idle cycles: pc = 0, 1, 2, 3. Assert rst_n low mid-run with pc=7: pc goes to 0 immediately and ras_err=0.
- At pc=10: branch_taken, sign_imm=5: next_pc=16. With sign_imm=-11: next_pc=0. With pc=all-ones and no controls: next_pc=0.
- Priority check: all controls high with stall=1: pc holds for 2 cycles and RAS is unchanged. Then ret+jump+branch_taken with RAS top=40: next_pc=40.
- Nested calls at pc=5 and then pc=20 (targets 20, 30), then ret twice: pc goes 20, 30, 21, 6, and ras_empty=1 afterwards.
- RAS_DEPTH=4: five calls from pcs 1,2,3,4,5:
  - ras_full=1 after the 4th call; the 5th call sets ras_err=1.
  - Four rets return 6,5,4,3.
  - A fifth ret gives next_pc=pc_plus1, ras_err stays 1, and ras_empty=1.
- Simultaneous call+ret at pc=8 with top=50: next_pc=50, top becomes 9, count unchanged. A subsequent ret yields 9.
